// File: rtl/cla_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_if
//  Description : Operand/result handshake bundle for the pipelined
//                carry-lookahead adder/subtractor (cla_pipe).
//                slave  - the adder side (consumes operands, produces results)
//                master - the client side (produces operands, consumes results)
//  Signals     : in_valid/out_ready    operand handshake
//                in_x, in_y            operands, WIDTH bits
//                in_carry, in_sub      carry-in (add only), subtract select
//                out_valid/in_ready    result handshake
//                out_sum               result, WIDTH bits
//                out_carry, out_overflow, out_zero, out_negative   status
//  Revision    : 1.0  initial release
// ============================================================================
interface cla_pipe_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             out_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             in_carry;
    logic             in_sub;
    logic             out_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_overflow;
    logic             out_zero;
    logic             out_negative;

    modport slave (
        input  in_valid, in_x, in_y, in_carry, in_sub, in_ready,
        output out_ready, out_valid, out_sum, out_carry,
               out_overflow, out_zero, out_negative
    );

    modport master (
        output in_valid, in_x, in_y, in_carry, in_sub, in_ready,
        input  out_ready, out_valid, out_sum, out_carry,
               out_overflow, out_zero, out_negative
    );
endinterface
`default_nettype wire

// File: rtl/cla_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe
//  Description : Parametrised pipelined carry-lookahead adder/subtractor.
//                A WIDTH-bit add is split into STAGES registered slices of
//                SW = WIDTH/STAGES bits. Each slice is built from 4-bit
//                lookahead groups; the slice carry-out is registered into the
//                next stage. Unconsumed operand slices are skewed forward and
//                finished sum slices ride along so all slices leave aligned.
//                Result appears STAGES cycles after the operand cycle.
//  Ports       : in_clk    clock, rising edge
//                in_reset  asynchronous active-high reset
//                bus       cla_pipe_if.slave (operand/result handshake)
//  Parameters  : WIDTH  operand width, multiple of 4*STAGES (default 32)
//                STAGES pipeline depth, 1..WIDTH/4 (default 2)
//  Macro       : CLA_PIPE_FLAGS_EN - when defined, out_overflow/out_zero/
//                out_negative are computed and registered; otherwise they
//                are tied to 0 and their registers are not built.
//  Revision    : 1.0  initial release
// ============================================================================
module cla_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  wire logic  in_clk,
    input  wire logic  in_reset,
    cla_pipe_if.slave  bus
);
    localparam int SW = WIDTH / STAGES;  // slice width
    localparam int NG = SW / 4;          // 4-bit groups per slice

    // One slice: bit g/p, 4-bit group lookahead for G/P, group carries from
    // the lookahead unit, then in-group carries expanded from the group
    // carry-in. Returns {carry_out, sum}.
    function automatic logic [SW:0] cla_slice(
        input logic [SW-1:0] a,
        input logic [SW-1:0] b,
        input logic          ci
    );
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW-1:0] c;
        logic [NG:0]   gc;
        logic          grp_g;
        logic          grp_p;
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        gc    = '0;
        gc[0] = ci;
        for (int j = 0; j < NG; j++) begin
            grp_g = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            grp_p = &p[4*j +: 4];
            gc[j+1] = grp_g | (grp_p & gc[j]);
        end
        for (int j = 0; j < NG; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1]
                     | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2]
                     | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        return {gc[NG], p ^ c};
    endfunction

    // Whole pipeline advances together; it only stops while a result is
    // waiting at the output and downstream refuses it.
    logic             w_en;
    logic [WIDTH-1:0] w_y_eff;
    logic             w_cin_eff;

    assign w_en          = ~bus.out_valid | bus.in_ready;
    assign bus.out_ready = w_en & ~in_reset;

    // Subtract is X + ~Y + 1; in_carry only matters for add.
    assign w_y_eff   = bus.in_sub ? ~bus.in_y : bus.in_y;
    assign w_cin_eff = bus.in_sub | bus.in_carry;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int RW = (STAGES - k) * SW;  // operand bits still to add

        logic [RW-1:0]         w_xr;
        logic [RW-1:0]         w_yr;
        logic                  w_ci;
        logic                  w_vin;
        logic [SW:0]           w_res;
        logic [(k+1)*SW-1:0]   w_sum_nxt;

        logic                  r_vld;
        logic                  r_c;
        logic [(k+1)*SW-1:0]   r_sum;

        assign w_res = cla_slice(w_xr[SW-1:0], w_yr[SW-1:0], w_ci);

        if (k == 0) begin : g_head
            assign w_xr      = bus.in_x;
            assign w_yr      = w_y_eff;
            assign w_ci      = w_cin_eff;
            assign w_vin     = bus.in_valid;
            assign w_sum_nxt = w_res[SW-1:0];
        end else begin : g_body
            assign w_xr      = g_stage[k-1].g_skew.r_x;
            assign w_yr      = g_stage[k-1].g_skew.r_y;
            assign w_ci      = g_stage[k-1].r_c;
            assign w_vin     = g_stage[k-1].r_vld;
            assign w_sum_nxt = {w_res[SW-1:0], g_stage[k-1].r_sum};
        end

        always_ff @(posedge in_clk or posedge in_reset) begin
            if (in_reset) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (w_en) begin
                r_vld <= w_vin;
                r_c   <= w_res[SW];
                r_sum <= w_sum_nxt;
            end
        end

        // Operand slices above this one wait here for the next stage.
        if (k < STAGES - 1) begin : g_skew
            logic [RW-SW-1:0] r_x;
            logic [RW-SW-1:0] r_y;

            always_ff @(posedge in_clk or posedge in_reset) begin
                if (in_reset) begin
                    r_x <= '0;
                    r_y <= '0;
                end else if (w_en) begin
                    r_x <= w_xr[RW-1:SW];
                    r_y <= w_yr[RW-1:SW];
                end
            end
        end

`ifdef CLA_PIPE_FLAGS_EN
        // Zero is the AND of every slice's zero detect, carried stage to stage.
        logic w_zin;
        logic r_zero;

        if (k == 0) begin : g_zhead
            assign w_zin = 1'b1;
        end else begin : g_zbody
            assign w_zin = g_stage[k-1].r_zero;
        end

        always_ff @(posedge in_clk or posedge in_reset) begin
            if (in_reset) begin
                r_zero <= 1'b0;
            end else if (w_en) begin
                r_zero <= w_zin & ~|w_res[SW-1:0];
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic r_ovf;
            logic r_neg;

            // Carry into the MSB is recovered as x ^ y ^ sum at that bit.
            always_ff @(posedge in_clk or posedge in_reset) begin
                if (in_reset) begin
                    r_ovf <= 1'b0;
                    r_neg <= 1'b0;
                end else if (w_en) begin
                    r_ovf <= w_xr[SW-1] ^ w_yr[SW-1] ^ w_res[SW-1] ^ w_res[SW];
                    r_neg <= w_res[SW-1];
                end
            end
        end
`endif
    end

    assign bus.out_valid = g_stage[STAGES-1].r_vld;
    assign bus.out_sum   = g_stage[STAGES-1].r_sum;
    assign bus.out_carry = g_stage[STAGES-1].r_c;

`ifdef CLA_PIPE_FLAGS_EN
    assign bus.out_overflow = g_stage[STAGES-1].g_last.r_ovf;
    assign bus.out_zero     = g_stage[STAGES-1].r_zero;
    assign bus.out_negative = g_stage[STAGES-1].g_last.r_neg;
`else
    assign bus.out_overflow = 1'b0;
    assign bus.out_zero     = 1'b0;
    assign bus.out_negative = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_pipe
//  Description : Directed self-checking bench for cla_pipe. Two instances
//                (STAGES=2 and STAGES=1, WIDTH=32) share the same stimulus;
//                'sel' chooses which one's outputs are checked. Flag
//                expectations follow CLA_PIPE_FLAGS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cla_pipe;
    localparam int WIDTH = 32;
`ifdef CLA_PIPE_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_x = '0;
    logic [31:0] in_y = '0;
    logic        in_carry = 1'b0;
    logic        in_sub = 1'b0;
    logic        in_ready = 1'b1;
    logic        sel = 1'b0;
    int          n_total = 0;
    int          n_bad = 0;

    cla_pipe_if #(.WIDTH(WIDTH)) bus2 ();
    cla_pipe_if #(.WIDTH(WIDTH)) bus1 ();

    assign bus2.in_valid = in_valid;
    assign bus2.in_x     = in_x;
    assign bus2.in_y     = in_y;
    assign bus2.in_carry = in_carry;
    assign bus2.in_sub   = in_sub;
    assign bus2.in_ready = in_ready;
    assign bus1.in_valid = in_valid;
    assign bus1.in_x     = in_x;
    assign bus1.in_y     = in_y;
    assign bus1.in_carry = in_carry;
    assign bus1.in_sub   = in_sub;
    assign bus1.in_ready = in_ready;

    cla_pipe #(.WIDTH(WIDTH), .STAGES(2)) u_dut2 (
        .in_clk   (clk),
        .in_reset (rst),
        .bus      (bus2)
    );

    cla_pipe #(.WIDTH(WIDTH), .STAGES(1)) u_dut1 (
        .in_clk   (clk),
        .in_reset (rst),
        .bus      (bus1)
    );

    logic        o_valid, o_ready, o_carry, o_ovf, o_zero, o_neg;
    logic [31:0] o_sum;
    assign o_valid = sel ? bus1.out_valid    : bus2.out_valid;
    assign o_ready = sel ? bus1.out_ready    : bus2.out_ready;
    assign o_sum   = sel ? bus1.out_sum      : bus2.out_sum;
    assign o_carry = sel ? bus1.out_carry    : bus2.out_carry;
    assign o_ovf   = sel ? bus1.out_overflow : bus2.out_overflow;
    assign o_zero  = sel ? bus1.out_zero     : bus2.out_zero;
    assign o_neg   = sel ? bus1.out_negative : bus2.out_negative;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish earlier");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".valid"}, 64'(o_valid), 64'd0);
        check({tag, ".sum"},   64'(o_sum),   64'd0);
        check({tag, ".carry"}, 64'(o_carry), 64'd0);
        check({tag, ".ovf"},   64'(o_ovf),   64'd0);
        check({tag, ".zero"},  64'(o_zero),  64'd0);
        check({tag, ".neg"},   64'(o_neg),   64'd0);
    endtask

    // Present one operand set, then wait (bounded) for its result and check
    // latency (cycles from the presenting cycle), sum and flags.
    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic cin, input logic sub, input logic [31:0] esum,
                          input logic ec, input logic ev, input logic ez, input logic en);
        int lat;
        @(posedge clk); #1;
        in_ready = 1'b1;
        in_valid = 1'b1;
        in_x = x; in_y = y; in_carry = cin; in_sub = sub;
        #1;
        check({tag, ".accept"}, 64'(o_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_x = '0; in_y = '0; in_carry = 1'b0; in_sub = 1'b0;
        lat = 1;
        while (!o_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), sel ? 64'd1 : 64'd2);
        check({tag, ".sum"},   64'(o_sum),   64'(esum));
        check({tag, ".carry"}, 64'(o_carry), 64'(ec));
        check({tag, ".ovf"},   64'(o_ovf),   64'(ev & FLAGS));
        check({tag, ".zero"},  64'(o_zero),  64'(ez & FLAGS));
        check({tag, ".neg"},   64'(o_neg),   64'(en & FLAGS));
    endtask

    // Fill the pipe (one op per stage), reset asynchronously mid-cycle and
    // check outputs clear at once, nothing leaks out afterwards, and the
    // next operation behaves normally.
    task automatic reset_midflight(input string tag, input int n_ops);
        logic [31:0] xs [2];
        xs[0] = 32'h7FFF_FFFF;
        xs[1] = 32'hFFFF_FFFF;
        for (int i = 0; i < n_ops; i++) begin
            @(posedge clk); #1;
            in_ready = 1'b1; in_valid = 1'b1;
            in_x = xs[i]; in_y = 32'd1; in_carry = 1'b0; in_sub = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".inflight"}, 64'(o_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs({tag, ".async"});
        check({tag, ".ready_in_reset"}, 64'(o_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check({tag, ".ready_after"}, 64'(o_ready), 64'd1);
        check({tag, ".drop0"}, 64'(o_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, ".drop1"}, 64'(o_valid), 64'd0);
        run_op({tag, ".next"}, 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Three back-to-back adds; downstream refuses for three cycles once the
    // first result shows up.
    task automatic backpressure();
        int  sent = 0;
        int  recv = 0;
        int  stall_left = 0;
        int  last_c = -1;
        bit  seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (o_valid && !seen) begin
                seen = 1'b1;
                stall_left = 3;
            end
            in_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            in_valid = (sent < 3);
            in_x = 32'(sent + 1); in_y = 32'(sent + 1);
            in_carry = 1'b0; in_sub = 1'b0;
            #1;
            if (!in_ready) begin
                check("bp.stall_ready", 64'(o_ready), 64'd0);
                check("bp.stall_valid", 64'(o_valid), 64'd1);
                check("bp.stall_sum",   64'(o_sum),   64'd2);
            end else if (o_valid) begin
                check("bp.order", 64'(o_sum), 64'(2 * (recv + 1)));
                if (recv > 0) check("bp.back_to_back", 64'(c), 64'(last_c + 1));
                last_c = c;
                recv++;
            end
            if (in_valid && o_ready) sent++;
        end
        in_valid = 1'b0; in_ready = 1'b1;
        check("bp.received", 64'(recv), 64'd3);
        check("bp.sent", 64'(sent), 64'd3);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset.ready", 64'(o_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset.ready_after", 64'(o_ready), 64'd1);

        // Two-stage build
        sel = 1'b0;
        //      tag          x              y              cin   sub   sum            c     v     z     n
        run_op("xslice",    32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("wrap",      32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("wrap_cin",  32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("sovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("sub_eq",    32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("sub_neg",   32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("zero_carry",32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        backpressure();
        reset_midflight("rst2", 2);

        // Single-stage build
        sel = 1'b0;
        @(posedge clk);
        sel = 1'b1;
        run_op("s1.add",    32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("s1.xgroup", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("s1.sub",    32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        reset_midflight("rst1", 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cla_pipe.md
# cla_pipe

Parametrised, pipelined carry-lookahead adder/subtractor for the Mini-SRC datapath, replacing the fixed 16-bit combinational adder where wider operands or a higher clock rate are needed. It splits a WIDTH-bit addition into STAGES registered slices, each built from 4-bit lookahead groups. A rippled carry is registered between slices. A valid/ready handshake on both sides lets the ALU stall it. Optional status flags (carry, overflow, zero, negative) feed the condition-code logic.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 4*STAGES
- STAGES, 2, pipeline depth in registered slices; 1..WIDTH/4; slice width SW = WIDTH/STAGES
- in_clk  input  1  clock, all state on rising edge
- in_reset  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand set present on in_x/in_y/in_carry/in_sub
- out_ready  output  1  block accepts an operand set this cycle
- in_x  input  WIDTH  operand X
- in_y  input  WIDTH  operand Y
- in_carry  input  1  carry-in (add mode only)
- in_sub  input  1  1 = subtract X - Y, 0 = add X + Y + in_carry
- out_valid  output  1  result present on outputs
- in_ready  input  1  downstream accepts result this cycle
- out_sum  output  WIDTH  result
- out_carry  output  1  carry out of bit WIDTH-1
- out_overflow  output  1  two's-complement overflow
- out_zero  output  1  out_sum == 0
- out_negative  output  1  out_sum[WIDTH-1]

## Operation
- Arithmetic: add = X + Y + in_carry. Sub = X + ~Y + 1, with in_carry ignored. Result is modulo 2^WIDTH.
- out_carry = carry out of MSB. For sub, 1 means no borrow (X >= Y unsigned).
- out_overflow = carry into MSB XOR carry out of MSB.
- Stage k (0..STAGES-1) adds slice k (bits k*SW+SW-1 : k*SW) using the registered carry from stage k-1. Stage 0 uses the effective carry-in.
- Each slice is composed of 4-bit groups with a group generate/propagate lookahead unit. There is no bit-level ripple inside a slice.
- Operand slices not yet consumed are skew-registered forward. Completed sum slices are delay-registered so that all slices emerge aligned.
- Each stage has a valid bit. The pipeline advances as a whole when enable = !out_valid || in_ready.
- out_ready = enable, forced 0 while in_reset is high.
- Transfer in: in_valid && out_ready. Transfer out: out_valid && in_ready.
- Bubbles propagate and do not collapse. Results leave in acceptance order.
- The STAGES=1 build is a single registered CLA (latency 1).

## Timing
- Latency: an operand set accepted on edge N appears with out_valid=1 after edge N+STAGES, if the pipeline is not stalled.
- Throughput: one result per cycle when in_ready is held 1.
- Stall: while out_valid=1 and in_ready=0, all pipeline registers and outputs hold and out_ready=0.
- Simultaneous in and out transfer in the same cycle is legal and is required for full throughput.
- Reset (asynchronous, any time, including mid-operation):
  - all valid bits cleared, so out_valid=0
  - out_sum=0, out_carry=0, out_overflow=0, out_zero=0, out_negative=0
  - in-flight operations are discarded
  - out_ready goes 1 on the first cycle after deassertion
- Outputs are driven directly from registers; there is no combinational path from in_x/in_y to outputs.
- in_ready → out_ready is a combinational path; this is intended.

## Configuration
- CLA_PIPE_FLAGS_EN defined:
  - out_overflow, out_zero and out_negative are computed from the final slice and registered alongside out_sum.
  - out_zero accumulates per-slice zero detects through the pipeline.
- Not defined:
  - These three outputs are tied to 0 and their pipeline registers are omitted.
  - out_carry and out_sum are unaffected.

## Test plan
All scenarios use WIDTH=32, STAGES=2 and CLA_PIPE_FLAGS_EN defined unless stated.
- Cross-slice carry: 0x0000FFFF + 0x00000001, cin=0 → sum 0x00010000, carry 0, out_valid exactly 2 cycles after accept.
- Wrap: 0xFFFFFFFF + 0x00000002 → sum 0x00000001, carry 1, overflow 0. Repeat with cin=1 → sum 0x00000002.
- Signed overflow: 0x7FFFFFFF + 0x00000001 → sum 0x80000000, overflow 1, negative 1, carry 0.
- Subtract: 5 - 5 with in_carry=1 → sum 0, zero 1, carry 1. Then 3 - 5 → 0xFFFFFFFE, carry 0, negative 1.
- Backpressure: 3 back-to-back adds (1+1, 2+2, 3+3) with in_ready low for 3 cycles once out_valid rises:
  - out_sum holds 2 and out_ready=0 during the stall
  - then 2, 4, 6 emerge on consecutive cycles
  - no loss or duplication
- Reset mid-flight: assert in_reset with 2 operations in flight → out_valid=0 and all outputs 0 immediately. After release, the next 0x1+0x1 gives 2 with latency 2. Repeat with the macro undefined (flags 0) and with STAGES=1 (latency 1).
